muldiv_unit: RTL

- Parametrised iterative multiply/divide unit with built-in HI/LO registers. It is the successor to the fixed 32-bit multiplier/divider pair.
- Adds the following over that pair:
  - signed and unsigned modes;
  - configurable operand width and radix (bits retired per cycle);
  - direct HI/LO writes for mthi/mtlo;
  - divide-by-zero reporting;
  - a single busy/done handshake to the control FSM.
- The datapath reads hi/lo for mfhi/mflo write-back.

---
 rtl/muldiv_unit.sv | 122 ++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed/unsigned multiply/divide with HI/LO result registers.
// Multiply is shift-add, divide is restoring. Both retire BPC bits per RUN cycle.
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int BPC = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_wr,
   input  logic             lo_wr,
   input  logic [WIDTH-1:0] wr_data,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int N = WIDTH / BPC;
   localparam int CW = $clog2(N + 1);
   typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;
   state_t state, state_nxt;
   logic [1:0] op_r;
   logic [WIDTH-1:0] a_r, b_r, mag_a, mag_b, quo, rem;
   logic neg_res, neg_rem, is_div, is_sgn, b_zero;
   logic [CW-1:0] cnt;
   logic [2*WIDTH-1:0] acc, acc_nxt, prod;
   logic [WIDTH:0] tmp;
   logic q;
   assign is_div = op_r[1];
   assign is_sgn = ~op_r[0];
   assign b_zero = b_r == '0;
   assign mag_a = is_sgn && a_r[WIDTH-1] ? -a_r : a_r;
   assign mag_b = is_sgn && b_r[WIDTH-1] ? -b_r : b_r;
   assign prod = neg_res ? -acc : acc;
   assign quo = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   assign rem = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else state <= state_nxt;
   end
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: state_nxt = start ? PREP : IDLE;
         PREP: state_nxt = is_div && b_zero ? IDLE : RUN;
         RUN:  state_nxt = cnt == CW'(1) ? FIX : RUN;
         FIX:  state_nxt = IDLE;
      endcase
   end
   // In RUN a_r/b_r hold magnitudes; acc is {partial, multiplier} or {remainder, quotient}
   always_comb begin
      acc_nxt = acc;
      tmp = '0;
      q = 1'b0;
      for (int i = 0; i < BPC; i++) begin
         if (is_div) begin
            tmp = acc_nxt[2*WIDTH-1:WIDTH-1];
            q = tmp >= {1'b0, b_r};
            tmp = q ? tmp - {1'b0, b_r} : tmp;
            acc_nxt = {tmp[WIDTH-1:0], acc_nxt[WIDTH-2:0], q};
         end else begin
            tmp = {1'b0, acc_nxt[2*WIDTH-1:WIDTH]} + (acc_nxt[0] ? {1'b0, a_r} : '0);
            acc_nxt = {tmp, acc_nxt[WIDTH-1:1]};
         end
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_r <= '0;
         a_r <= '0;
         b_r <= '0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         cnt <= '0;
         acc <= '0;
         hi <= '0;
         lo <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         div_by_zero <= 1'b0;
         busy <= state_nxt != IDLE;
         if (!busy && hi_wr) hi <= wr_data;
         if (!busy && lo_wr) lo <= wr_data;
         case (state)
            IDLE: if (start) begin
               op_r <= op;
               a_r <= a;
               b_r <= b;
            end
            PREP: begin
               neg_res <= is_sgn & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
               neg_rem <= is_sgn & a_r[WIDTH-1];
               a_r <= mag_a;
               b_r <= mag_b;
               cnt <= CW'(N);
               acc <= {{WIDTH{1'b0}}, is_div ? mag_a : mag_b};
               if (is_div && b_zero) begin
                  hi <= a_r;
                  lo <= '1;
                  done <= 1'b1;
                  div_by_zero <= 1'b1;
               end
            end
            RUN: begin
               acc <= acc_nxt;
               cnt <= cnt - CW'(1);
            end
            FIX: begin
               {hi, lo} <= is_div ? {rem, quo} : prod;
               done <= 1'b1;
            end
         endcase
      end
   end
endmodule
